// File: rtl/wl_cmd_sequencer.sv
// Word-line command sequencer: FIFO-buffered commands driving DAC codes and
// timed wl_addr_en / wl_pre_op_en pulses. Optional stats via WL_SEQ_STATS_EN.
module wl_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETTLE_CYC = 4,
  parameter int PULSE_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [7:0]  cmd_code,
  output logic [63:0] dac_code,
  output logic        wl_addr_en,
  output logic        wl_pre_op_en,
  output logic [4:0]  wl_addr,
  output logic        busy,
  output logic        done
`ifdef WL_SEQ_STATS_EN
  ,
  output logic [15:0] cmd_cnt,
  output logic [15:0] rej_cnt
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PW   = AW + 1;
  localparam int MAXC = (SETTLE_CYC > PULSE_CYC) ? SETTLE_CYC : PULSE_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_PRE   = 2'b10;

  typedef struct packed {
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] code;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SETTLE, S_PULSE, S_HOLD, S_DONE
  } state_e;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cmd_t          cmd_q, cmd_d;
  logic [63:0]   dac_q, dac_d;
  logic [4:0]    addr_q, addr_d;
  logic          aen_q, aen_d;
  logic          pen_q, pen_d;
  logic          done_q, done_d;
  logic          full, empty, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = cmd_valid && !full;

  assign cmd_ready    = !full;
  assign dac_code     = dac_q;
  assign wl_addr      = addr_q;
  assign wl_addr_en   = aen_q;
  assign wl_pre_op_en = pen_q;
  assign done         = done_q;
  assign busy         = (state_q != S_IDLE) || !empty;

`ifdef WL_SEQ_STATS_EN
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [15:0] rej_cnt_q, rej_cnt_d;
  assign cmd_cnt = cmd_cnt_q;
  assign rej_cnt = rej_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_addr, cmd_code};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    cmd_d    = cmd_q;
    dac_d    = dac_q;
    addr_d   = addr_q;
    aen_d    = aen_q;
    pen_d    = pen_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          cmd_d    = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d = rd_ptr_q + PW'(1);
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        unique case (cmd_q.op)
          OP_LOAD: begin
            dac_d[{cmd_q.addr[2:0], 3'b000} +: 8] = cmd_q.code;
            state_d = S_DONE;
          end
          OP_WRITE, OP_PRE: begin
            addr_d  = (cmd_q.op == OP_WRITE) ? cmd_q.addr : 5'd0;
            cnt_d   = CW'(SETTLE_CYC - 1);
            state_d = S_SETTLE;
          end
          default: state_d = S_DONE;
        endcase
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          aen_d   = (cmd_q.op == OP_WRITE);
          pen_d   = (cmd_q.op == OP_PRE);
          cnt_d   = CW'(PULSE_CYC - 1);
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          aen_d   = 1'b0;
          pen_d   = 1'b0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: state_d = S_DONE;
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef WL_SEQ_STATS_EN
    cmd_cnt_d = cmd_cnt_q;
    rej_cnt_d = rej_cnt_q;
    if (done_d && cmd_cnt_q != 16'hFFFF) cmd_cnt_d = cmd_cnt_q + 16'd1;
    if (cmd_valid && full && rej_cnt_q != 16'hFFFF) rej_cnt_d = rej_cnt_q + 16'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      dac_q    <= '0;
      addr_q   <= '0;
      aen_q    <= 1'b0;
      pen_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef WL_SEQ_STATS_EN
      cmd_cnt_q <= '0;
      rej_cnt_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      dac_q    <= dac_d;
      addr_q   <= addr_d;
      aen_q    <= aen_d;
      pen_q    <= pen_d;
      done_q   <= done_d;
`ifdef WL_SEQ_STATS_EN
      cmd_cnt_q <= cmd_cnt_d;
      rej_cnt_q <= rej_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_wl_cmd_sequencer.sv
// Directed bench for wl_cmd_sequencer with hand-computed expectations.
// Stats checks are built only when WL_SEQ_STATS_EN is defined.
module tb_wl_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [7:0]  cmd_code;
  logic [63:0] dac_code;
  logic        wl_addr_en;
  logic        wl_pre_op_en;
  logic [4:0]  wl_addr;
  logic        busy;
  logic        done;
`ifdef WL_SEQ_STATS_EN
  logic [15:0] cmd_cnt;
  logic [15:0] rej_cnt;
`endif

  wl_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_code(cmd_code),
    .dac_code(dac_code),
    .wl_addr_en(wl_addr_en), .wl_pre_op_en(wl_pre_op_en),
    .wl_addr(wl_addr), .busy(busy), .done(done)
`ifdef WL_SEQ_STATS_EN
    , .cmd_cnt(cmd_cnt), .rej_cnt(rej_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int n_aen = 0;
  int n_both = 0;
  logic [63:0] exp_dac;

  always @(negedge clk) begin
    if (done) n_done++;
    if (wl_addr_en) n_aen++;
    if (wl_addr_en && wl_pre_op_en) n_both++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_one(input logic [1:0] op, input logic [4:0] a,
                          input logic [7:0] c, output int held);
    held = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_code  = c;
    while (!cmd_ready && held < 50) begin
      @(negedge clk);
      held++;
    end
    if (held >= 50) chk("push_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Index k = number of edges after the push edge.
  task automatic run_cmd(input string tag, input logic [1:0] op,
                         input logic [4:0] a, input logic [7:0] c,
                         input int e_fa, input int e_na,
                         input int e_fp, input int e_np,
                         input int e_done, input logic [4:0] e_addr);
    int held;
    int fa, na, fp, np, di, nd;
    fa = -1; na = 0; fp = -1; np = 0; di = -1; nd = 0;
    push_one(op, a, c, held);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (wl_addr_en) begin
        if (fa < 0) fa = k;
        na++;
      end
      if (wl_pre_op_en) begin
        if (fp < 0) fp = k;
        np++;
      end
      if (done) begin
        if (di < 0) di = k;
        nd++;
      end
    end
    chk({tag, "_aen_first"}, 64'(fa), 64'(e_fa));
    chk({tag, "_aen_cycles"}, 64'(na), 64'(e_na));
    chk({tag, "_pen_first"}, 64'(fp), 64'(e_fp));
    chk({tag, "_pen_cycles"}, 64'(np), 64'(e_np));
    chk({tag, "_done_at"}, 64'(di), 64'(e_done));
    chk({tag, "_done_cnt"}, 64'(nd), 64'd1);
    chk({tag, "_wl_addr"}, 64'(wl_addr), 64'(e_addr));
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  int held;
  int base_done, base_aen, seen;
  logic [2:0] slots [5];
  logic [7:0] codes [5];

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = 5'd0;
    cmd_code = 8'd0;
    exp_dac = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dac", dac_code, 64'd0);
    chk("rst_addr", 64'(wl_addr), 64'd0);
    chk("rst_aen", 64'(wl_addr_en), 64'd0);
    chk("rst_pen", 64'(wl_pre_op_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    run_cmd("load", 2'b00, 5'b00011, 8'hA5, -1, 0, -1, 0, 3, 5'd0);
    exp_dac[31:24] = 8'hA5;
    chk("load_dac", dac_code, 64'h0000_0000_A500_0000);

    run_cmd("write", 2'b01, 5'b10011, 8'h00, 6, 2, -1, 0, 10, 5'd19);
    run_cmd("pre", 2'b10, 5'b00111, 8'h00, -1, 0, 6, 2, 10, 5'd0);
    run_cmd("nop", 2'b11, 5'b11111, 8'hFF, -1, 0, -1, 0, 3, 5'd0);
    chk("nop_dac", dac_code, exp_dac);

    // Back-to-back: FIFO fills behind a long WRITE; slot 1 loaded twice for order.
    slots[0] = 3'd1; codes[0] = 8'h11;
    slots[1] = 3'd2; codes[1] = 8'h22;
    slots[2] = 3'd1; codes[2] = 8'h33;
    slots[3] = 3'd4; codes[3] = 8'h44;
    slots[4] = 3'd5; codes[4] = 8'h55;
    base_done = n_done;
    push_one(2'b01, 5'b00001, 8'h00, held);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push_one(2'b00, {2'b00, slots[i]}, codes[i], held);
      exp_dac[{slots[i], 3'b000} +: 8] = codes[i];
      if (i < 4) chk("b2b_no_stall", 64'(held), 64'd0);
      if (i == 3) chk("b2b_full_ready", 64'(cmd_ready), 64'd0);
      if (i == 4) chk("b2b_fifth_held", 64'(held != 0), 64'd1);
    end
    repeat (40) @(negedge clk);
    chk("b2b_done_cnt", 64'(n_done - base_done), 64'd6);
    chk("b2b_dac", dac_code, exp_dac);
    chk("b2b_wl_addr", 64'(wl_addr), 64'd1);
    chk("b2b_busy", 64'(busy), 64'd0);

    // Reset during PULSE with two commands queued.
    push_one(2'b01, 5'b01010, 8'h00, held);
    push_one(2'b00, 5'b00110, 8'h77, held);
    push_one(2'b00, 5'b00111, 8'h88, held);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (wl_addr_en) seen = 1;
    end
    chk("rp_pulse_seen", 64'(seen), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rp_aen", 64'(wl_addr_en), 64'd0);
    chk("rp_pen", 64'(wl_pre_op_en), 64'd0);
    chk("rp_dac", dac_code, 64'd0);
    chk("rp_busy", 64'(busy), 64'd0);
    chk("rp_done", 64'(done), 64'd0);
    chk("rp_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;
    exp_dac = '0;
    base_done = n_done;
    base_aen = n_aen;
    repeat (30) @(negedge clk);
    chk("rp_no_done", 64'(n_done - base_done), 64'd0);
    chk("rp_no_aen", 64'(n_aen - base_aen), 64'd0);
    chk("rp_dac_after", dac_code, 64'd0);

`ifdef WL_SEQ_STATS_EN
    chk("st_rst_cmd", 64'(cmd_cnt), 64'd0);
    chk("st_rst_rej", 64'(rej_cnt), 64'd0);
    push_one(2'b01, 5'b00010, 8'h00, held);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      push_one(2'b00, {2'b00, slots[i]}, codes[i], held);
    @(negedge clk);
    chk("st_full", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("st_rej_cnt", 64'(rej_cnt), 64'd3);
    chk("st_cmd_cnt", 64'(cmd_cnt), 64'd5);
`endif

    chk("never_both_en", 64'(n_both), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
